// File: rtl/share_encoder.sv
// Splits each accepted byte into two Boolean shares (data^mask, mask) drawn from an 8-bit LFSR
// and streams them as four 2-bit beats per share, MSB pair first.
module share_encoder #(
    parameter logic [7:0] SEED = 8'hB8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       reseed,
    input  logic [7:0] seed_in,
    output logic [1:0] Aq,
    output logic [1:0] Bq,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    typedef enum logic {StIdle, StSend} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] share_a_q, share_b_q;
    logic [7:0] lfsr_q, lfsr_next;
    logic       accept;
    logic       idle;
    logic [1:0] a_beat, b_beat;

    assign idle      = (state_q == StIdle);
    assign in_ready  = idle & ~reseed & ~rst;
    assign accept    = in_valid & in_ready;
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSend;
                    cnt_d   = 2'd0;
                end
            end
            StSend: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            share_a_q <= 8'h00;
            share_b_q <= 8'h00;
            lfsr_q    <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                share_a_q <= in_data ^ lfsr_q;
                share_b_q <= lfsr_q;
            end
            // Reseed only lands in IDLE; a zero seed would lock the LFSR at zero.
            if (idle && reseed) begin
                lfsr_q <= (seed_in == 8'h00) ? SEED : seed_in;
            end else if (accept) begin
                lfsr_q <= lfsr_next;
            end
        end
    end

    // Each lane selects only from its own share register.
    always_comb begin
        a_beat = 2'd0;
        b_beat = 2'd0;
        unique case (cnt_q)
            2'd0: begin
                a_beat = share_a_q[7:6];
                b_beat = share_b_q[7:6];
            end
            2'd1: begin
                a_beat = share_a_q[5:4];
                b_beat = share_b_q[5:4];
            end
            2'd2: begin
                a_beat = share_a_q[3:2];
                b_beat = share_b_q[3:2];
            end
            2'd3: begin
                a_beat = share_a_q[1:0];
                b_beat = share_b_q[1:0];
            end
            default: begin
                a_beat = 2'd0;
                b_beat = 2'd0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == StSend);
        Aq        = out_valid ? a_beat : 2'd0;
        Bq        = out_valid ? b_beat : 2'd0;
        out_last  = out_valid & (cnt_q == 2'd3);
    end

endmodule
